// File: rtl/mult_div_unit.sv
// mult_div_unit: 32-bit signed Booth multiplier and restoring divider, fixed 33-cycle latency
module mult_div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        div_zero
);
  typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;
  state_t      state_q;
  logic [5:0]  cnt_q;
  logic [31:0] m_q;
  logic [64:0] acc_q;
  logic [31:0] rem_q;
  logic        sq_q, sr_q, div_q;
  logic [31:0] hi_q, lo_q;
  logic        busy_q, done_q, dz_q;
  logic [31:0] a_abs, b_abs, q_fin, r_fin, quo_d, rem_d;
  logic [32:0] sum, shl;
  logic [64:0] booth_d;
  logic        ge, go_mult, go_div;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = dz_q;
  // Booth step on the sign-extended upper half, restoring-division step, and final sign fix-up
  always_comb begin
    a_abs   = a[31] ? -a : a;
    b_abs   = b[31] ? -b : b;
    go_mult = start && op == 2'b01;
    go_div  = start && op == 2'b10 && b != 32'd0;
    sum     = {acc_q[64], acc_q[64:33]} + (acc_q[1:0] == 2'b01 ? {m_q[31], m_q} :
                                           acc_q[1:0] == 2'b10 ? -{m_q[31], m_q} : 33'd0);
    booth_d = {sum, acc_q[32:1]};
    shl     = {rem_q, acc_q[31]};
    ge      = shl >= {1'b0, m_q};
    rem_d   = ge ? 32'(shl - {1'b0, m_q}) : shl[31:0];
    quo_d   = {acc_q[30:0], ge};
    q_fin   = sq_q ? -acc_q[31:0] : acc_q[31:0];
    r_fin   = sr_q ? -rem_q : rem_q;
  end
  // Control FSM with registered results and status flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 6'd0;
      m_q     <= 32'd0;
      acc_q   <= 65'd0;
      rem_q   <= 32'd0;
      sq_q    <= 1'b0;
      sr_q    <= 1'b0;
      div_q   <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (go_mult || go_div) begin
            state_q <= go_mult ? MULT : DIV;
            cnt_q   <= 6'd0;
            m_q     <= go_mult ? a : b_abs;
            acc_q   <= go_mult ? {32'd0, b, 1'b0} : {33'd0, a_abs};
            rem_q   <= 32'd0;
            sq_q    <= a[31] ^ b[31];
            sr_q    <= a[31];
            div_q   <= go_div;
            busy_q  <= 1'b1;
            dz_q    <= 1'b0;
          end else if (start && op == 2'b10) begin
            dz_q   <= 1'b1;
            done_q <= 1'b1;
          end
        end
        MULT: begin
          acc_q <= booth_d;
          cnt_q <= cnt_q + 6'd1;
          if (cnt_q == 6'd31) state_q <= DONE;
        end
        DIV: begin
          acc_q <= {acc_q[64:32], quo_d};
          rem_q <= rem_d;
          cnt_q <= cnt_q + 6'd1;
          if (cnt_q == 6'd31) state_q <= DONE;
        end
        DONE: begin
          hi_q    <= div_q ? r_fin : acc_q[64:33];
          lo_q    <= div_q ? q_fin : acc_q[32:1];
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed checks of multiply, divide, divide-by-zero, busy lockout and reset
module tb_mult_div_unit;
  logic        clk = 1'b0;
  logic        reset, start, busy, done, div_zero;
  logic [1:0]  op;
  logic [31:0] a, b, hi, lo;
  int          tests = 0, fails = 0, nd = 0;
  always #5 clk = ~clk;
  mult_div_unit dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .div_zero(div_zero)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  // start is sampled on the next edge (E0); operands are scrambled afterwards
  task automatic go(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    tick();
    start = 1'b0;
    op    = 2'b00;
    a     = 32'hA5A5A5A5;
    b     = 32'h5A5A5A5A;
  endtask
  // advance from just after E0 to just after E33, counting early done pulses
  task automatic wait_done;
    nd = 0;
    repeat (32) begin
      tick();
      if (done) nd++;
    end
    tick();
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  initial begin
    reset = 1'b1;
    start = 1'b0;
    op    = 2'b00;
    a     = 32'd0;
    b     = 32'd0;
    #2 reset = 1'b0;
    #1;
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_dz", div_zero, 1'b0);
    repeat (2) tick();
    reset = 1'b1;
    tick();
    go(2'b11, 32'd1, 32'd1);
    chk1("op11_busy", busy, 1'b0);
    chk1("op11_done", done, 1'b0);
    go(2'b01, 32'd7, 32'hFFFFFFFD);
    chk1("s1_busy", busy, 1'b1);
    wait_done();
    chk("s1_early_done", nd, 0);
    chk1("s1_done", done, 1'b1);
    chk1("s1_busy_clr", busy, 1'b0);
    chk("s1_hi", hi, 32'hFFFFFFFF);
    chk("s1_lo", lo, 32'hFFFFFFEB);
    go(2'b01, 32'h80000000, 32'h80000000);
    chk1("s2_done_drop", done, 1'b0);
    chk1("s2_b2b_busy", busy, 1'b1);
    wait_done();
    chk("s2_early_done", nd, 0);
    chk1("s2_done", done, 1'b1);
    chk("s2_hi", hi, 32'h40000000);
    chk("s2_lo", lo, 32'h00000000);
    tick();
    chk1("s2_done_once", done, 1'b0);
    chk("s2_hold_hi", hi, 32'h40000000);
    go(2'b10, 32'hFFFFFFF9, 32'd2);
    wait_done();
    chk1("s3_done", done, 1'b1);
    chk("s3_lo", lo, 32'hFFFFFFFD);
    chk("s3_hi", hi, 32'hFFFFFFFF);
    chk1("s3_dz", div_zero, 1'b0);
    tick();
    go(2'b10, 32'h80000000, 32'hFFFFFFFF);
    wait_done();
    chk("s4_lo", lo, 32'h80000000);
    chk("s4_hi", hi, 32'h00000000);
    chk1("s4_dz", div_zero, 1'b0);
    tick();
    go(2'b10, 32'd5, 32'd0);
    chk1("dz_flag", div_zero, 1'b1);
    chk1("dz_done", done, 1'b1);
    chk1("dz_busy", busy, 1'b0);
    chk("dz_hi", hi, 32'h00000000);
    chk("dz_lo", lo, 32'h80000000);
    tick();
    chk1("dz_done_once", done, 1'b0);
    chk1("dz_hold", div_zero, 1'b1);
    chk1("dz_idle", busy, 1'b0);
    go(2'b01, 32'hFFFFFFFB, 32'd6);
    chk1("dz_clear", div_zero, 1'b0);
    wait_done();
    chk("s5_hi", hi, 32'hFFFFFFFF);
    chk("s5_lo", lo, 32'hFFFFFFE2);
    tick();
    go(2'b01, 32'h00012345, 32'h00000100);
    nd = 0;
    repeat (9) begin
      tick();
      if (done) nd++;
    end
    start = 1'b1;
    op    = 2'b01;
    a     = 32'd9;
    b     = 32'd9;
    tick();
    if (done) nd++;
    start = 1'b0;
    op    = 2'b00;
    repeat (22) begin
      tick();
      if (done) nd++;
    end
    tick();
    chk("s6_early_done", nd, 0);
    chk1("s6_done", done, 1'b1);
    chk("s6_hi", hi, 32'h00000000);
    chk("s6_lo", lo, 32'h01234500);
    tick();
    chk1("s6_no_restart", busy, 1'b0);
    chk1("s6_done_once", done, 1'b0);
    go(2'b10, 32'd100, 32'd7);
    repeat (14) tick();
    #2 reset = 1'b0;
    #1;
    chk("s7_rst_hi", hi, 32'd0);
    chk("s7_rst_lo", lo, 32'd0);
    chk1("s7_rst_busy", busy, 1'b0);
    chk1("s7_rst_done", done, 1'b0);
    chk1("s7_rst_dz", div_zero, 1'b0);
    repeat (3) tick();
    reset = 1'b1;
    nd = 0;
    repeat (40) begin
      tick();
      if (done) nd++;
    end
    chk("s7_no_done", nd, 0);
    chk1("s7_idle", busy, 1'b0);
    go(2'b01, 32'd3, 32'd4);
    wait_done();
    chk1("s7_done", done, 1'b1);
    chk("s7_lo", lo, 32'd12);
    chk("s7_hi", hi, 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL use one clock; reset is asynchronous and active-low. Clock port `clk`, reset port `reset`.
REQ-002 SHALL expose these ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous reset, active-low
- start  in  1  begin operation; sampled on a rising edge
- op  in  2  operation select: 00 none, 01 MULT, 10 DIV, 11 none
- a  in  32  operand A (multiplicand / dividend), two's complement
- b  in  32  operand B (multiplier / divisor), two's complement
- hi  out  32  HI result: product[63:32] or remainder
- lo  out  32  LO result: product[31:0] or quotient
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse
- div_zero  out  1  divide-by-zero flag

Function
REQ-003 SHALL implement the FSM states IDLE, MULT, DIV and DONE.
REQ-004 In IDLE, start=1 with op=01 SHALL latch a and b, clear the 6-bit iteration counter, set busy and go to MULT.
REQ-005 In IDLE, start=1 with op=10 and b!=0 SHALL latch a and b, clear the counter, set busy and go to DIV.
REQ-006 In IDLE, start=1 with op=00 or op=11 SHALL be ignored; no output changes.
REQ-007 MULT SHALL perform signed radix-2 Booth multiplication, one iteration per clock, 32 iterations; the product is the full 64-bit signed value.
REQ-008 DIV SHALL perform restoring division on operand magnitudes, one iteration per clock, 32 iterations, then apply signs:
- quotient truncates toward zero;
- remainder takes the sign of the dividend.
REQ-009 After 32 iterations the FSM SHALL enter DONE, register hi/lo, pulse done=1 for exactly one cycle, clear busy and return to IDLE.
REQ-010 Latency SHALL be fixed: if start is sampled on edge E0, done=1 and hi/lo are valid immediately after edge E33.
REQ-011 busy SHALL be 1 from edge E0 until edge E33.
REQ-012 DIV with b=0 SHALL NOT enter DIV. It SHALL instead, on edge E0:
- set div_zero=1;
- pulse done for one cycle (done valid after E0);
- leave hi/lo unchanged;
- remain in IDLE.
REQ-013 div_zero SHALL hold until the next accepted start (op 01 or 10), which clears it; a successful operation leaves it 0.
REQ-014 start SHALL be ignored while busy=1; operand inputs SHALL NOT affect an operation in progress.
REQ-015 DIV 0x80000000 / 0xFFFFFFFF SHALL yield lo=0x80000000, hi=0x00000000, with no flag raised.
REQ-016 hi/lo SHALL change only on DONE entry or reset; they hold their value between operations.
REQ-017 All datapath arithmetic SHALL use a 65-bit Booth accumulator and a 33-bit partial remainder; no intermediate truncation.
REQ-018 start=1 in the same cycle that done=1 SHALL be accepted, since the FSM is already in IDLE, giving back-to-back operations.

Reset
REQ-019 reset=0 SHALL immediately, without waiting for a clock edge, force:
- state IDLE, counter 0;
- hi=0, lo=0;
- busy=0, done=0, div_zero=0.
REQ-020 Reset asserted mid-operation SHALL abandon the operation; no done pulse follows it.
REQ-021 After reset release, the first start SHALL behave as from a clean IDLE.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- MULT a=7, b=0xFFFFFFFD -> after E33: hi=0xFFFFFFFF, lo=0xFFFFFFEB, done high one cycle.
- MULT a=0x80000000, b=0x80000000 -> hi=0x40000000, lo=0x00000000.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF, div_zero=0.
- DIV a=5, b=0 -> after E0: div_zero=1, done pulse, hi/lo unchanged, busy stays 0; a following MULT start clears div_zero.
- Second start pulsed at E10 during a MULT -> ignored; exactly one done, at E33; result is from the first operands.
- reset=0 asserted at E15 of a DIV -> outputs zero immediately; no done; a new MULT 3x4 then gives lo=12, hi=0 at +33 cycles.
